// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM sequencing fetch, decode, execute, memory and writeback
//
// Optional feature: define INSTRET_COUNT_EN to add the 64-bit retired-instruction counter output instret.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   imem_addr, imem_req     fetch address (always pc) and fetch request
//   imem_ready, imem_rdata  instruction handshake and fetched word
//   dmem_ready              data memory has completed the current access
//   addr_lsb                low two bits of the datapath effective address
//   rd, rs1, rs2            register indices
//   opcode, func3, func7    decoded fields (func7 is 0 outside R-type)
//   imm                     sign-extended I- or S-format immediate
//   reg_write               register-file write strobe
//   mem_write_enable        store byte lanes, nonzero only with store_enable
//   store_enable            store strobe
//   mem_read_enable         load strobe
//   trap                    sticky fault flag, cleared only by reset
//   pc                      current program counter
//   instret                 retired-instruction count (INSTRET_COUNT_EN only)
module multicycle_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        dmem_ready,
    input  logic [1:0]  addr_lsb,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [31:0] imm,
    output logic        reg_write,
    output logic [3:0]  mem_write_enable,
    output logic        store_enable,
    output logic        mem_read_enable,
    output logic        trap,
`ifdef INSTRET_COUNT_EN
    output logic [63:0] instret,
`endif
    output logic [31:0] pc
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    state_t      state;
    logic [31:0] ir;
    logic [7:0]  wait_cnt;
    logic [6:0]  ir_op;
    logic        ir_r;
    logic        ir_store;
    logic        ir_ok;
    logic [31:0] ir_imm;
    logic        is_store;
    logic        is_mem;
    logic        misaligned;
    logic [3:0]  lanes;

    // Decode helpers work on IR; execute/memory helpers work on the registered fields.
    always_comb begin
        ir_op      = ir[6:0];
        ir_r       = ir_op == OP_R;
        ir_store   = ir_op == OP_STORE;
        ir_ok      = ir_r || ir_store || ir_op == OP_I || ir_op == OP_LOAD;
        ir_imm     = ir_store ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
                     (ir_r || !ir_ok) ? 32'h0 : {{20{ir[31]}}, ir[31:20]};
        is_store   = opcode == OP_STORE;
        is_mem     = is_store || opcode == OP_LOAD;
        // func3[1:0] encodes access size: 00 byte, 01 half, 10 word
        misaligned = (func3[1:0] == 2'b01 && addr_lsb[0]) ||
                     (func3[1:0] == 2'b10 && addr_lsb != 2'b00);
        lanes      = func3[1:0] == 2'b00 ? 4'b0001 << addr_lsb :
                     func3[1:0] == 2'b01 ? 4'b0011 << addr_lsb : 4'b1111;
    end

    assign imem_addr = pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= S_FETCH;
            pc               <= RESET_PC;
            ir               <= '0;
            wait_cnt         <= '0;
            imem_req         <= 1'b0;
            rd               <= '0;
            rs1              <= '0;
            rs2              <= '0;
            opcode           <= '0;
            func3            <= '0;
            func7            <= '0;
            imm              <= '0;
            reg_write        <= 1'b0;
            mem_write_enable <= '0;
            store_enable     <= 1'b0;
            mem_read_enable  <= 1'b0;
            trap             <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    // The request is raised one cycle before an instruction can be accepted after reset
                    if (imem_req && imem_ready) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    rd     <= ir[11:7];
                    rs1    <= ir[19:15];
                    rs2    <= ir[24:20];
                    opcode <= ir_op;
                    func3  <= ir[14:12];
                    func7  <= ir_r ? ir[31:25] : 7'h0;
                    imm    <= ir_imm;
                    trap   <= !ir_ok;
                    state  <= ir_ok ? S_EXECUTE : S_TRAP;
                end
                S_EXECUTE: begin
                    if (!is_mem) begin
                        reg_write <= rd != 5'd0;
                        state     <= S_WRITEBACK;
                    end else if (misaligned) begin
                        trap  <= 1'b1;
                        state <= S_TRAP;
                    end else begin
                        wait_cnt         <= '0;
                        store_enable     <= is_store;
                        mem_write_enable <= is_store ? lanes : 4'b0000;
                        mem_read_enable  <= !is_store;
                        state            <= S_MEMORY;
                    end
                end
                S_MEMORY: begin
                    if (dmem_ready) begin
                        store_enable     <= 1'b0;
                        mem_write_enable <= '0;
                        mem_read_enable  <= 1'b0;
                        if (is_store) begin
                            pc       <= pc + 32'd4;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            reg_write <= rd != 5'd0;
                            state     <= S_WRITEBACK;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        store_enable     <= 1'b0;
                        mem_write_enable <= '0;
                        mem_read_enable  <= 1'b0;
                        trap             <= 1'b1;
                        state            <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WRITEBACK: begin
                    reg_write <= 1'b0;
                    pc        <= pc + 32'd4;
                    imem_req  <= 1'b1;
                    state     <= S_FETCH;
                end
                S_TRAP: begin
                    trap <= 1'b1;
                end
                default: begin
                    trap  <= 1'b1;
                    state <= S_TRAP;
                end
            endcase
        end
    end

`ifdef INSTRET_COUNT_EN
    // Retirement points: end of WRITEBACK, or a store completing in MEMORY
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            instret <= '0;
        else if (state == S_WRITEBACK || (state == S_MEMORY && is_store && dmem_ready))
            instret <= instret + 64'd1;
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [31:0] I_ADDI5  = 32'h0070_0293;
    localparam logic [31:0] I_ADDIM1 = 32'hFFF0_0193;
    localparam logic [31:0] I_ADD0   = 32'h0020_8033;
    localparam logic [31:0] I_SUB7   = 32'h4020_83B3;
    localparam logic [31:0] I_SBM4   = 32'hFE62_8E23;
    localparam logic [31:0] I_SH     = 32'h0062_9023;
    localparam logic [31:0] I_LW     = 32'h0082_A483;
    localparam logic [31:0] I_JAL    = 32'h0000_006F;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_ready;
    logic [1:0]  addr_lsb;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic        reg_write;
    logic [3:0]  mem_write_enable;
    logic        store_enable;
    logic        mem_read_enable;
    logic        trap;
    logic [31:0] pc;
`ifdef INSTRET_COUNT_EN
    logic [63:0] instret;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_pc;

    always #5 clock = ~clock;

    multicycle_ctrl #(.RESET_PC(RESET_PC), .MEM_TIMEOUT(16)) dut (
        .clock(clock),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_req(imem_req),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .dmem_ready(dmem_ready),
        .addr_lsb(addr_lsb),
        .rd(rd),
        .rs1(rs1),
        .rs2(rs2),
        .opcode(opcode),
        .func3(func3),
        .func7(func7),
        .imm(imm),
        .reg_write(reg_write),
        .mem_write_enable(mem_write_enable),
        .store_enable(store_enable),
        .mem_read_enable(mem_read_enable),
        .trap(trap),
`ifdef INSTRET_COUNT_EN
        .instret(instret),
`endif
        .pc(pc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Strobe exclusivity holds on every cycle outside reset
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            check("strobe_excl", 64'($countones({reg_write, store_enable, mem_read_enable}) > 1), 64'd0);
            check("mwe_gate", 64'(mem_write_enable != 4'b0000 && !store_enable), 64'd0);
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_pc", pc, RESET_PC);
        check("rst_trap", trap, 1'b0);
        check("rst_rd_en", mem_read_enable, 1'b0);
        check("rst_st_en", store_enable, 1'b0);
        check("rst_we", reg_write, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        step(1);
        check("rst_req_rise", imem_req, 1'b1);
        exp_pc = RESET_PC;
    endtask

    task automatic run_alu(input logic [31:0] instr, input logic [4:0] erd, input logic [6:0] ef7,
                           input logic [31:0] eimm, input logic ewe);
        imem_rdata = instr;
        step(1);
        check("dec_req", imem_req, 1'b0);
        step(1);
        check("ex_rd", rd, erd);
        check("ex_f7", func7, ef7);
        if (instr[6:0] != 7'b0110011)
            check("ex_imm", imm, eimm);
        check("ex_we", reg_write, 1'b0);
        step(1);
        check("wb_we", reg_write, ewe);
        check("wb_pc", pc, exp_pc);
        step(1);
        exp_pc += 32'd4;
        check("f_pc", pc, exp_pc);
        check("f_addr", imem_addr, exp_pc);
        check("f_req", imem_req, 1'b1);
        check("f_we", reg_write, 1'b0);
    endtask

    task automatic run_store(input logic [31:0] instr, input logic [1:0] lsb, input int waits,
                             input logic [3:0] emwe, input logic [31:0] eimm);
        imem_rdata = instr;
        addr_lsb   = lsb;
        dmem_ready = 1'b0;
        step(2);
        check("st_ex_imm", imm, eimm);
        check("st_ex_op", opcode, 7'b0100011);
        check("st_ex_en", store_enable, 1'b0);
        step(1);
        for (int i = 0; i < waits; i++) begin
            check("st_en", store_enable, 1'b1);
            check("st_mwe", mem_write_enable, emwe);
            check("st_we", reg_write, 1'b0);
            if (i == waits - 1)
                dmem_ready = 1'b1;
            step(1);
        end
        dmem_ready = 1'b0;
        exp_pc += 32'd4;
        check("st_done_en", store_enable, 1'b0);
        check("st_done_mwe", mem_write_enable, 4'b0000);
        check("st_done_pc", pc, exp_pc);
        check("st_done_req", imem_req, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = I_ADDI5;
        dmem_ready = 1'b0;
        addr_lsb   = 2'b00;
        exp_pc     = RESET_PC;
        #2;
        do_reset();
        run_alu(I_ADDI5, 5'd5, 7'h00, 32'd7, 1'b1);
        run_store(I_SBM4, 2'b10, 3, 4'b0100, 32'hFFFF_FFFC);
        run_store(I_SH, 2'b10, 1, 4'b1100, 32'h0);
        run_alu(I_ADD0, 5'd0, 7'h00, 32'h0, 1'b0);
        run_alu(I_SUB7, 5'd7, 7'h20, 32'h0, 1'b1);
        run_alu(I_ADDIM1, 5'd3, 7'h00, 32'hFFFF_FFFF, 1'b1);
        // Zero-wait aligned load: five cycles fetch to fetch
        imem_rdata = I_LW;
        addr_lsb   = 2'b00;
        dmem_ready = 1'b1;
        step(2);
        check("ld_imm", imm, 32'd8);
        check("ld_rd", rd, 5'd9);
        step(1);
        check("ld_mem_rd", mem_read_enable, 1'b1);
        check("ld_mem_we", reg_write, 1'b0);
        step(1);
        check("ld_wb_we", reg_write, 1'b1);
        check("ld_wb_rd_en", mem_read_enable, 1'b0);
        step(1);
        exp_pc += 32'd4;
        check("ld_pc", pc, exp_pc);
        check("ld_req", imem_req, 1'b1);
        dmem_ready = 1'b0;
        // Fetch stalls indefinitely, then reset during the wait
        imem_ready = 1'b0;
        step(3);
        check("wait_req", imem_req, 1'b1);
        check("wait_pc", pc, 32'd28);
        do_reset();
        imem_ready = 1'b1;
        // Misaligned word load traps without any strobe
        imem_rdata = I_LW;
        addr_lsb   = 2'b01;
        dmem_ready = 1'b1;
        step(2);
        check("mis_ex_trap", trap, 1'b0);
        step(1);
        check("mis_trap", trap, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("mis_hold_trap", trap, 1'b1);
            check("mis_rd_en", mem_read_enable, 1'b0);
            check("mis_req", imem_req, 1'b0);
            check("mis_pc", pc, RESET_PC);
            step(1);
        end
        dmem_ready = 1'b0;
        addr_lsb   = 2'b00;
        do_reset();
        // Unsupported opcode traps after decode with pc frozen
        run_alu(I_ADDI5, 5'd5, 7'h00, 32'd7, 1'b1);
        imem_rdata = I_JAL;
        step(1);
        check("jal_dec_trap", trap, 1'b0);
        step(1);
        for (int i = 0; i < 3; i++) begin
            check("jal_trap", trap, 1'b1);
            check("jal_pc", pc, 32'd4);
            check("jal_req", imem_req, 1'b0);
            step(1);
        end
        do_reset();
        // Load with dmem_ready stuck low: trap exactly 16 cycles after MEMORY entry
        imem_rdata = I_LW;
        step(3);
        check("to_entry_rd", mem_read_enable, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            step(1);
            check("to_trap", trap, 1'(i == 16));
            check("to_rd_en", mem_read_enable, 1'(i != 16));
        end
        step(1);
        check("to_after_trap", trap, 1'b1);
        check("to_after_rd", mem_read_enable, 1'b0);
        do_reset();
        // Reset in the middle of a memory wait drops the strobe at once
        run_alu(I_ADDI5, 5'd5, 7'h00, 32'd7, 1'b1);
        imem_rdata = I_LW;
        step(3);
        step(2);
        check("mid_rd_en", mem_read_enable, 1'b1);
        do_reset();
        run_alu(I_ADDI5, 5'd5, 7'h00, 32'd7, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
